sgd_x_updated_gen: RTL and testbench

SGD_X_UPDATED_GEN -- requirements
Module: sgd_x_updated_gen

---
 rtl/sgd_x_updated_gen.sv | 200 ++++++++++++++++++++
 tb/tb_sgd_x_updated_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sgd_x_updated_gen.sv
// sgd_x_updated_gen: applies one SGD step per model chunk.
// Gradient chunks arrive in chunk-index order; the matching model chunk is
// read from BRAM, each 32-bit lane becomes sat32(x - (g >>> step)), and the
// result is emitted for write-back. Throughput is one chunk per cycle with
// no stall. A chunk tagged "last" marks the end of one full model update.
module sgd_x_updated_gen #(
  parameter int LANES       = 8,
  parameter int ADDR_W      = 8,
  parameter int CHUNK_SHIFT = 6,
  parameter int RD_LAT      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  started,
  input  logic [31:0]           dimension,
  input  logic [4:0]            step_shift,
  input  logic                  grad_valid,
  input  logic [ADDR_W-1:0]     grad_addr,
  input  logic [LANES*32-1:0]   grad_data,
  output logic                  x_rd_en,
  output logic [ADDR_W-1:0]     x_rd_addr,
  input  logic [LANES*32-1:0]   x_rd_data,
  output logic                  x_updated_wr_en,
  output logic [ADDR_W-1:0]     x_updated_wr_addr,
  output logic [LANES*32-1:0]   x_updated_wr_data,
  output logic                  update_done,
  output logic [31:0]           update_count,
  output logic                  update_error,
  output logic [31:0]           state_counters
);

  localparam int DW = LANES * 32;
  // Stage 0 drives the BRAM address; stage NS-1 lines up with the read data.
  localparam int NS = RD_LAT + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t              state_reg;
  logic                started_reg;
  logic [31:0]         dimension_reg;
  logic [4:0]          step_shift_reg;
  logic [11:0]         chunk_index_reg;
  logic [31:0]         update_count_reg;
  logic                update_done_reg;
  logic                update_error_reg;

  logic [NS-1:0]       p_valid_reg;
  logic [NS-1:0]       p_last_reg;
  logic [ADDR_W-1:0]   p_addr_reg [NS];
  logic [DW-1:0]       p_grad_reg [NS];

  logic                wr_en_reg;
  logic [ADDR_W-1:0]   wr_addr_reg;
  logic [DW-1:0]       wr_data_reg;
  logic [DW-1:0]       x_new;

  logic [11:0]         num_chunks;
  logic                accept;
  logic                addr_match;
  logic                is_last;
  logic                acc_last;
  logic                drain;
  logic                more_last;

  // Ceiling of dimension / chunk size, truncated to the 12-bit index space.
  assign num_chunks = 12'(dimension_reg >> CHUNK_SHIFT)
                    + {11'd0, |dimension_reg[CHUNK_SHIFT-1:0]};

  assign accept     = grad_valid && started_reg &&
                      (state_reg == S_RUN || state_reg == S_FLUSH);
  assign addr_match = (32'(grad_addr) == 32'(chunk_index_reg));
  assign is_last    = (chunk_index_reg == num_chunks - 12'd1);
  // Only an in-order final chunk closes an update; a mismatched one does not.
  assign acc_last   = accept && addr_match && is_last;
  // The final chunk of an update is being written at this edge.
  assign drain      = p_valid_reg[NS-1] && p_last_reg[NS-1];
  // Another update's final chunk is still in flight (or entering now).
  assign more_last  = |(p_valid_reg[NS-2:0] & p_last_reg[NS-2:0]) || acc_last;

  // Capture run configuration so the datapath only sees stable copies.
  always_ff @(posedge clk) begin
    dimension_reg  <= dimension;
    step_shift_reg <= step_shift;
  end

  // Control FSM: chunk ordering, update completion and the sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_reg      <= 1'b0;
      state_reg        <= S_IDLE;
      chunk_index_reg  <= '0;
      update_count_reg <= '0;
      update_done_reg  <= 1'b0;
      update_error_reg <= 1'b0;
    end else begin
      started_reg     <= started;
      update_done_reg <= 1'b0;
      if (!started_reg) begin
        state_reg       <= S_IDLE;
        chunk_index_reg <= '0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            state_reg        <= S_CHECK;
            update_error_reg <= 1'b0;
          end
          S_CHECK: begin
            chunk_index_reg <= '0;
            if (num_chunks == 12'd0) begin
              state_reg        <= S_ERROR;
              update_error_reg <= 1'b1;
            end else begin
              state_reg <= S_RUN;
            end
          end
          S_RUN, S_FLUSH: begin
            if (accept) begin
              if (!addr_match)
                update_error_reg <= 1'b1;
              else if (is_last)
                chunk_index_reg <= '0;
              else
                chunk_index_reg <= chunk_index_reg + 12'd1;
            end
            if (state_reg == S_FLUSH && drain) begin
              update_done_reg  <= 1'b1;
              update_count_reg <= update_count_reg + 32'd1;
            end
            if (accept && !addr_match)
              state_reg <= S_ERROR;
            else if (state_reg == S_RUN) begin
              if (acc_last)
                state_reg <= S_FLUSH;
            end else if (drain && !more_last)
              state_reg <= S_RUN;
          end
          default: state_reg <= S_ERROR;
        endcase
      end
    end
  end

  // Pipeline valids and last tags; flushed by reset so nothing writes after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_reg <= '0;
      p_last_reg  <= '0;
      wr_en_reg   <= 1'b0;
    end else begin
      p_valid_reg <= {p_valid_reg[NS-2:0], accept};
      p_last_reg  <= {p_last_reg[NS-2:0], acc_last};
      wr_en_reg   <= p_valid_reg[NS-1];
    end
  end

  // Address/gradient travel alongside the BRAM read; result is registered.
  always_ff @(posedge clk) begin
    p_addr_reg[0] <= grad_addr;
    p_grad_reg[0] <= grad_data;
    for (int i = 1; i < NS; i++) begin
      p_addr_reg[i] <= p_addr_reg[i-1];
      p_grad_reg[i] <= p_grad_reg[i-1];
    end
    wr_addr_reg <= p_addr_reg[NS-1];
    wr_data_reg <= x_new;
  end

  // Per-lane saturating update: 33-bit difference clamped to int32 range.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [31:0] x_old;
      logic signed [31:0] g;
      logic signed [31:0] g_sh;
      logic        [32:0] diff;
      assign x_old = x_rd_data[32*gi +: 32];
      assign g     = p_grad_reg[NS-1][32*gi +: 32];
      assign g_sh  = g >>> step_shift_reg;
      assign diff  = {x_old[31], x_old} - {g_sh[31], g_sh};
      assign x_new[32*gi +: 32] = (diff[32] == diff[31]) ? diff[31:0]
                                : (diff[32] ? 32'h8000_0000 : 32'h7FFF_FFFF);
    end
  endgenerate

  assign x_rd_en           = p_valid_reg[0];
  assign x_rd_addr         = p_addr_reg[0];
  assign x_updated_wr_en   = wr_en_reg;
  assign x_updated_wr_addr = wr_addr_reg;
  assign x_updated_wr_data = wr_data_reg;
  assign update_done       = update_done_reg;
  assign update_count      = update_count_reg;
  assign update_error      = update_error_reg;
  assign state_counters    = {state_reg, chunk_index_reg, update_count_reg[16:0]};

endmodule

// File: tb/tb_sgd_x_updated_gen.sv
// Directed bench for sgd_x_updated_gen: table of single-run vectors plus
// hand-written sequences for ordering error, mid-update reset and FLUSH overlap.
module tb_sgd_x_updated_gen;

  localparam int LANES  = 8;
  localparam int ADDR_W = 8;
  localparam int DW     = LANES * 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_ERROR = 3'd4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              started;
  logic [31:0]       dimension;
  logic [4:0]        step_shift;
  logic              grad_valid;
  logic [ADDR_W-1:0] grad_addr;
  logic [DW-1:0]     grad_data;
  logic              x_rd_en;
  logic [ADDR_W-1:0] x_rd_addr;
  logic [DW-1:0]     x_rd_data;
  logic              x_updated_wr_en;
  logic [ADDR_W-1:0] x_updated_wr_addr;
  logic [DW-1:0]     x_updated_wr_data;
  logic              update_done;
  logic [31:0]       update_count;
  logic              update_error;
  logic [31:0]       state_counters;

  sgd_x_updated_gen #(.LANES(LANES), .ADDR_W(ADDR_W), .CHUNK_SHIFT(6), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .started(started), .dimension(dimension),
    .step_shift(step_shift), .grad_valid(grad_valid), .grad_addr(grad_addr),
    .grad_data(grad_data), .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr),
    .x_rd_data(x_rd_data), .x_updated_wr_en(x_updated_wr_en),
    .x_updated_wr_addr(x_updated_wr_addr), .x_updated_wr_data(x_updated_wr_data),
    .update_done(update_done), .update_count(update_count),
    .update_error(update_error), .state_counters(state_counters)
  );

  always #5 clk = ~clk;

  // Model BRAM, one-cycle registered read.
  logic [DW-1:0] mem [256];
  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (x_rd_en) x_rd_data <= mem[x_rd_addr];
  end

  // Write and done monitor.
  logic [ADDR_W-1:0] log_addr [512];
  logic [DW-1:0]     log_data [512];
  int                log_cyc  [512];
  int                log_n    = 0;
  int                done_cnt = 0;
  always @(negedge clk) begin
    if (x_updated_wr_en && log_n < 512) begin
      log_addr[log_n] = x_updated_wr_addr;
      log_data[log_n] = x_updated_wr_data;
      log_cyc[log_n]  = cyc;
      log_n           = log_n + 1;
    end
    if (update_done) done_cnt = done_cnt + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [31:0] v);
    return {LANES{v}};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; started = 1'b0; grad_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_run(input logic [31:0] dim, input logic [4:0] sh);
    dimension = dim; step_shift = sh; started = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send(input int a, input logic [31:0] g, output int t);
    grad_valid = 1'b1;
    grad_addr  = ADDR_W'(a);
    grad_data  = rep(g);
    t = cyc;
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] dim;
    logic [4:0]  sh;
    logic [31:0] x_old;
    logic [31:0] grad;
    int          n;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int t0, t, base, dbase, nw;

    vecs[0] = '{128, 0, 100, 1, 2, 99, 0};
    vecs[1] = '{65, 0, 10, 3, 2, 7, 0};
    vecs[2] = '{64, 0, 10, 3, 1, 7, 0};
    vecs[3] = '{1, 1, 10, 4, 1, 8, 0};
    vecs[4] = '{0, 0, 10, 4, 0, 0, 1};
    vecs[5] = '{64, 2, 32'h7FFF_FFF0, 32'hFFFF_FF00, 1, 32'h7FFF_FFFF, 0};
    vecs[6] = '{64, 4, 32'hFFFF_FFFB, 16, 1, 32'hFFFF_FFFA, 0};
    vecs[7] = '{64, 0, 32'h8000_0000, 256, 1, 32'h8000_0000, 0};
    vecs[8] = '{64, 1, 1000, 32'hFFFF_FFF9, 1, 1004, 0};
    vecs[9] = '{64, 31, 50, 32'h7FFF_FFFF, 1, 50, 0};

    dimension = 0; step_shift = 0; grad_addr = 0; grad_data = 0;
    started = 0; grad_valid = 0; x_rd_data = 0;
    rst_n = 1'b0;
    #1;
    chk("reset_wr_en", DW'(x_updated_wr_en), 0);
    chk("reset_rd_en", DW'(x_rd_en), 0);
    chk("reset_done", DW'(update_done), 0);
    chk("reset_error", DW'(update_error), 0);
    chk("reset_count", DW'(update_count), 0);
    chk("reset_state", DW'(state_counters[31:29]), DW'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single-update runs.
    for (int v = 0; v < 10; v++) begin
      do_reset();
      for (int a = 0; a < 4; a++) mem[a] = rep(vecs[v].x_old);
      start_run(vecs[v].dim, vecs[v].sh);
      base = log_n; dbase = done_cnt; t0 = cyc;
      for (int i = 0; i < ((vecs[v].n == 0) ? 1 : vecs[v].n); i++) begin
        send(i, vecs[v].grad, t);
        if (i == 0) t0 = t;
      end
      grad_valid = 1'b0;
      repeat (8) @(negedge clk);
      nw = log_n - base;
      chk($sformatf("v%0d_writes", v), DW'(nw), DW'(vecs[v].n));
      for (int i = 0; i < vecs[v].n && i < nw; i++) begin
        chk($sformatf("v%0d_addr%0d", v, i), DW'(log_addr[base+i]), DW'(i));
        chk($sformatf("v%0d_data%0d", v, i), log_data[base+i], rep(vecs[v].exp));
        chk($sformatf("v%0d_cyc%0d", v, i), DW'(log_cyc[base+i] - t0), DW'(3 + i));
      end
      chk($sformatf("v%0d_done", v), DW'(done_cnt - dbase), DW'(vecs[v].err ? 0 : 1));
      chk($sformatf("v%0d_count", v), DW'(update_count), DW'(vecs[v].err ? 0 : 1));
      chk($sformatf("v%0d_error", v), DW'(update_error), DW'(vecs[v].err));
      chk($sformatf("v%0d_state", v), DW'(state_counters[31:29]),
          DW'(vecs[v].err ? ST_ERROR : ST_RUN));
    end

    // Out-of-order chunk: written anyway, then sticky error until restart.
    do_reset();
    for (int a = 0; a < 4; a++) mem[a] = rep(32'd500);
    start_run(256, 0);
    base = log_n;
    send(0, 5, t0);
    send(2, 5, t);
    grad_valid = 1'b0;
    repeat (6) @(negedge clk);
    nw = log_n - base;
    chk("ooo_writes", DW'(nw), 2);
    if (nw >= 2) begin
      chk("ooo_addr", DW'(log_addr[base+1]), 2);
      chk("ooo_data", log_data[base+1], rep(32'd495));
    end
    chk("ooo_error", DW'(update_error), 1);
    chk("ooo_state", DW'(state_counters[31:29]), DW'(ST_ERROR));
    send(1, 5, t);
    grad_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("ooo_ignored", DW'(log_n - base), 2);
    started = 1'b0;
    repeat (2) @(negedge clk);
    chk("ooo_idle", DW'(state_counters[31:29]), DW'(ST_IDLE));
    chk("ooo_err_held", DW'(update_error), 1);
    started = 1'b1;
    repeat (3) @(negedge clk);
    chk("ooo_err_clr", DW'(update_error), 0);
    chk("ooo_rerun", DW'(state_counters[31:29]), DW'(ST_RUN));

    // Reset while chunks of a 3-chunk update are in flight.
    do_reset();
    for (int a = 0; a < 4; a++) mem[a] = rep(32'd7);
    start_run(192, 0);
    send(0, 1, t0);
    send(1, 1, t);
    grad_valid = 1'b0;
    rst_n = 1'b0; started = 1'b0;
    base = log_n;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_no_write", DW'(log_n - base), 0);
    chk("rst_count", DW'(update_count), 0);

    // Next update's chunk 0 arrives during FLUSH.
    do_reset();
    for (int a = 0; a < 4; a++) mem[a] = rep(32'd40);
    start_run(128, 3);
    base = log_n; dbase = done_cnt;
    send(0, 16, t0);
    send(1, 16, t);
    send(0, 16, t);
    send(1, 16, t);
    grad_valid = 1'b0;
    repeat (10) @(negedge clk);
    nw = log_n - base;
    chk("ovl_writes", DW'(nw), 4);
    for (int i = 0; i < 4 && i < nw; i++) begin
      chk($sformatf("ovl_addr%0d", i), DW'(log_addr[base+i]), DW'(i % 2));
      chk($sformatf("ovl_data%0d", i), log_data[base+i], rep(32'd38));
    end
    chk("ovl_done", DW'(done_cnt - dbase), 2);
    chk("ovl_count", DW'(update_count), 2);
    chk("ovl_error", DW'(update_error), 0);
    chk("ovl_state", DW'(state_counters[31:29]), DW'(ST_RUN));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
